// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one fixed-latency pipelined CORDIC between two
// AXI-Stream I/Q requesters. Round-robin admission with per-channel credits
// (output FIFO space minus in-flight samples) so a CORDIC result, which
// cannot be stalled, always has room in its channel's output FIFO.
// Optional build macro: CORDIC_ARB_STATS_EN adds saturating 16-bit
// accept/stall counters (stat_ch0_cnt, stat_ch1_cnt, stat_stall_cnt).

// First-word-fall-through FIFO; rdata reads 0 while empty.
module cordic_arb_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since rdata is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

module cordic_arbiter #(
  parameter int DATA_W     = 32,
  parameter int CORDIC_LAT = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              s00_axis_aclk,
  input  logic              s00_axis_areset,
  input  logic              s00_axis_tvalid,
  output logic              s00_axis_tready,
  input  logic              s00_axis_tlast,
  input  logic [DATA_W-1:0] s00_axis_tdata,
  input  logic              s01_axis_tvalid,
  output logic              s01_axis_tready,
  input  logic              s01_axis_tlast,
  input  logic [DATA_W-1:0] s01_axis_tdata,
  output logic              cordic_in_tvalid,
  output logic [DATA_W-1:0] cordic_in_tdata,
  output logic              cordic_in_tlast,
  input  logic              cordic_out_tvalid,
  input  logic [DATA_W-1:0] cordic_out_tdata,
  input  logic              cordic_out_tlast,
  output logic              m00_axis_tvalid,
  input  logic              m00_axis_tready,
  output logic              m00_axis_tlast,
  output logic [DATA_W-1:0] m00_axis_tdata,
  output logic              m01_axis_tvalid,
  input  logic              m01_axis_tready,
  output logic              m01_axis_tlast,
  output logic [DATA_W-1:0] m01_axis_tdata,
  output logic              err_orphan
`ifdef CORDIC_ARB_STATS_EN
  ,
  output logic [15:0]       stat_ch0_cnt,
  output logic [15:0]       stat_ch1_cnt,
  output logic [15:0]       stat_stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(2 * FIFO_DEPTH) + 1;
  localparam int QW = $clog2(CORDIC_LAT + 2);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic clk, rst;
  assign clk = s00_axis_aclk;
  assign rst = s00_axis_areset;

  logic [1:0]             s_tvalid, s_tlast, elig, grant, ret_push, m_tready, m_tvalid;
  logic [1:0][DATA_W-1:0] s_tdata;
  logic [1:0][DATA_W:0]   m_word;
  logic [1:0][CW-1:0]     fifo_cnt, inflight;
  logic [1:0][CW:0]       used;
  logic                   last_gnt, sel, hs;
  logic [0:0]             tag;
  logic [TW-1:0]          tag_cnt;
  logic                   tag_empty, ret_ok, orphan;
  logic [QW-1:0]          quiet;

  assign s_tvalid = {s01_axis_tvalid, s00_axis_tvalid};
  assign s_tlast  = {s01_axis_tlast,  s00_axis_tlast};
  assign s_tdata  = {s01_axis_tdata,  s00_axis_tdata};
  assign m_tready = {m01_axis_tready, m00_axis_tready};

  // Per-channel credit check and output FIFO.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    assign used[g]     = {1'b0, fifo_cnt[g]} + {1'b0, inflight[g]};
    assign elig[g]     = s_tvalid[g] & (used[g] < DEPTH_L);
    assign m_tvalid[g] = (fifo_cnt[g] != '0);

    cordic_arb_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ret_push[g]),
      .wdata ({cordic_out_tlast, cordic_out_tdata}),
      .pop   (m_tready[g]),
      .rdata (m_word[g]),
      .count (fifo_cnt[g])
    );
  end

  assign m00_axis_tvalid = m_tvalid[0];
  assign m00_axis_tlast  = m_word[0][DATA_W];
  assign m00_axis_tdata  = m_word[0][DATA_W-1:0];
  assign m01_axis_tvalid = m_tvalid[1];
  assign m01_axis_tlast  = m_word[1][DATA_W];
  assign m01_axis_tdata  = m_word[1][DATA_W-1:0];

  // Round-robin grant: on contention, favour the channel not granted last.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_gnt ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign s00_axis_tready = grant[0];
  assign s01_axis_tready = grant[1];
  assign hs  = |grant;
  assign sel = grant[1];

  // Last-granted pointer; reset value 1 makes ch0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst)     last_gnt <= 1'b1;
    else if (hs) last_gnt <= sel;
  end

  // Issue register towards the CORDIC.
  always_ff @(posedge clk) begin
    if (rst) begin
      cordic_in_tvalid <= 1'b0;
      cordic_in_tdata  <= '0;
      cordic_in_tlast  <= 1'b0;
    end else begin
      cordic_in_tvalid <= hs;
      if (hs) begin
        cordic_in_tdata <= s_tdata[sel];
        cordic_in_tlast <= s_tlast[sel];
      end
    end
  end

  // Tag FIFO remembers the owner of each issued sample, in issue order.
  cordic_arb_fifo #(.W(1), .DEPTH(2 * FIFO_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hs),
    .wdata (sel),
    .pop   (cordic_out_tvalid),
    .rdata (tag),
    .count (tag_cnt)
  );

  assign tag_empty = (tag_cnt == '0);
  assign ret_ok    = cordic_out_tvalid & ~tag_empty & ~rst;
  assign orphan    = cordic_out_tvalid & tag_empty;

  // Steer a returning result to the FIFO of its tagged channel.
  always_comb begin
    ret_push = 2'b00;
    if (ret_ok) ret_push[tag[0]] = 1'b1;
  end

  // In-flight counters: +1 on grant, -1 on return, both leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        case ({grant[c], ret_push[c]})
          2'b10:   inflight[c] <= inflight[c] + CW'(1);
          2'b01:   inflight[c] <= inflight[c] - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Quiet window after reset: results issued before reset drain silently.
  always_ff @(posedge clk) begin
    if (rst)              quiet <= QW'(CORDIC_LAT + 1);
    else if (quiet != '0) quiet <= quiet - QW'(1);
  end

  // Sticky orphan flag.
  always_ff @(posedge clk) begin
    if (rst)                          err_orphan <= 1'b0;
    else if (orphan && quiet == '0)   err_orphan <= 1'b1;
  end

`ifdef CORDIC_ARB_STATS_EN
  logic stall;
  assign stall = |(s_tvalid & ~elig);

  // Saturating accept and credit-stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ch0_cnt   <= '0;
      stat_ch1_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (grant[0] && stat_ch0_cnt != 16'hFFFF)  stat_ch0_cnt   <= stat_ch0_cnt + 16'd1;
      if (grant[1] && stat_ch1_cnt != 16'hFFFF)  stat_ch1_cnt   <= stat_ch1_cnt + 16'd1;
      if (stall && stat_stall_cnt != 16'hFFFF)   stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a behavioural CORDIC delay line
// that swaps the 16-bit halves of each sample.
module tb_cordic_arbiter;
  localparam int DW  = 32;
  localparam int LAT = 16;
  localparam int FD  = 32;

  logic clk = 1'b0;
  logic rst;
  logic s00_tvalid, s00_tready, s00_tlast;
  logic [DW-1:0] s00_tdata;
  logic s01_tvalid, s01_tready, s01_tlast;
  logic [DW-1:0] s01_tdata;
  logic ci_v, ci_l;
  logic [DW-1:0] ci_d;
  logic co_v, co_l;
  logic [DW-1:0] co_d;
  logic m00_tvalid, m00_tready, m00_tlast;
  logic [DW-1:0] m00_tdata;
  logic m01_tvalid, m01_tready, m01_tlast;
  logic [DW-1:0] m01_tdata;
  logic err_orphan;
`ifdef CORDIC_ARB_STATS_EN
  logic [15:0] stat_ch0_cnt, stat_ch1_cnt, stat_stall_cnt;
`endif

  cordic_arbiter #(.DATA_W(DW), .CORDIC_LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tvalid(s00_tvalid), .s00_axis_tready(s00_tready),
    .s00_axis_tlast(s00_tlast), .s00_axis_tdata(s00_tdata),
    .s01_axis_tvalid(s01_tvalid), .s01_axis_tready(s01_tready),
    .s01_axis_tlast(s01_tlast), .s01_axis_tdata(s01_tdata),
    .cordic_in_tvalid(ci_v), .cordic_in_tdata(ci_d), .cordic_in_tlast(ci_l),
    .cordic_out_tvalid(co_v), .cordic_out_tdata(co_d), .cordic_out_tlast(co_l),
    .m00_axis_tvalid(m00_tvalid), .m00_axis_tready(m00_tready),
    .m00_axis_tlast(m00_tlast), .m00_axis_tdata(m00_tdata),
    .m01_axis_tvalid(m01_tvalid), .m01_axis_tready(m01_tready),
    .m01_axis_tlast(m01_tlast), .m01_axis_tdata(m01_tdata),
    .err_orphan(err_orphan)
`ifdef CORDIC_ARB_STATS_EN
    , .stat_ch0_cnt(stat_ch0_cnt), .stat_ch1_cnt(stat_ch1_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CORDIC model: LAT-stage delay line, result = halves swapped.
  logic [LAT-1:0] pv = '0;
  logic [LAT-1:0] pl = '0;
  logic [DW-1:0]  pd [LAT];
  logic           inj_v = 1'b0;
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], ci_v};
    pl <= {pl[LAT-2:0], ci_l};
    pd[0] <= ci_d;
    for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
  end
  assign co_v = pv[LAT-1] | inj_v;
  assign co_d = {pd[LAT-1][15:0], pd[LAT-1][31:16]};
  assign co_l = pl[LAT-1];

  function automatic logic [DW-1:0] swp(input logic [DW-1:0] d);
    return {d[15:0], d[31:16]};
  endfunction

  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected {tlast,result} per channel, grant order, accept counts.
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  int gq[$];
  int acc0 = 0;
  int acc1 = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (s00_tvalid && s00_tready) begin q0.push_back({s00_tlast, swp(s00_tdata)}); acc0++; gq.push_back(0); end
      if (s01_tvalid && s01_tready) begin q1.push_back({s01_tlast, swp(s01_tdata)}); acc1++; gq.push_back(1); end
      if (s00_tready && s01_tready) chk("tready_both", 1, 0);
      if (m00_tvalid && m00_tready) begin
        if (q0.size() == 0) chk("m00_unexpected", 1, 0);
        else chk("m00_data", {m00_tlast, m00_tdata}, q0.pop_front());
      end
      if (m01_tvalid && m01_tready) begin
        if (q1.size() == 0) chk("m01_unexpected", 1, 0);
        else chk("m01_data", {m01_tlast, m01_tdata}, q1.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete(); q1.delete();
  endtask

  task automatic stream(input int n0, input int n1, input logic [DW-1:0] b0,
                        input logic [DW-1:0] b1, input int budget, output bit ok);
    int i0 = 0;
    int i1 = 0;
    int k = 0;
    logic h0, h1;
    @(posedge clk); #1;
    s00_tvalid = (n0 > 0); s00_tdata = b0; s00_tlast = (n0 == 1);
    s01_tvalid = (n1 > 0); s01_tdata = b1; s01_tlast = (n1 == 1);
    while ((i0 < n0 || i1 < n1) && k < budget) begin
      @(negedge clk);
      h0 = s00_tvalid & s00_tready;
      h1 = s01_tvalid & s01_tready;
      @(posedge clk); #1;
      k++;
      if (h0) begin i0++; s00_tvalid = (i0 < n0); s00_tdata = b0 + DW'(i0); s00_tlast = (i0 == n0 - 1); end
      if (h1) begin i1++; s01_tvalid = (i1 < n1); s01_tdata = b1 + DW'(i1); s01_tlast = (i1 == n1 - 1); end
    end
    s00_tvalid = 1'b0; s01_tvalid = 1'b0;
    ok = (i0 >= n0) && (i1 >= n1);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 300) begin
      @(negedge clk); k++;
    end
    chk(nm, q0.size() + q1.size(), 0);
  endtask

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic        last;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t vec[6];

  initial begin
    bit ok;
    int t_hs, t_out, other, got_last, base0, c1stall, seen_v, seen_ret, k;
    logic [DW-1:0] got;

    vec[0] = '{0, 32'h0001_0002, 1'b0, 32'h0002_0001, 1'b0};
    vec[1] = '{1, 32'h1234_5678, 1'b1, 32'h5678_1234, 1'b1};
    vec[2] = '{0, 32'hFFFF_0000, 1'b1, 32'h0000_FFFF, 1'b1};
    vec[3] = '{1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vec[4] = '{0, 32'hDEAD_BEEF, 1'b1, 32'hBEEF_DEAD, 1'b1};
    vec[5] = '{1, 32'h8000_0001, 1'b0, 32'h0001_8000, 1'b0};

    rst = 1'b1;
    s00_tvalid = 1'b1; s00_tdata = 32'hAAAA_5555; s00_tlast = 1'b1;
    s01_tvalid = 1'b1; s01_tdata = 32'h5555_AAAA; s01_tlast = 1'b1;
    m00_tready = 1'b1; m01_tready = 1'b1;

    // Reset state, with requests pending to show tready is held low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s00_tready", s00_tready, 0);
    chk("rst_s01_tready", s01_tready, 0);
    chk("rst_cordic_in_tvalid", ci_v, 0);
    chk("rst_cordic_in_tdata", ci_d, 0);
    chk("rst_m_tvalid", {m00_tvalid, m01_tvalid}, 0);
    chk("rst_m_tdata", {m00_tdata, m01_tdata}, 0);
    chk("rst_m_tlast", {m00_tlast, m01_tlast}, 0);
    chk("rst_err_orphan", err_orphan, 0);
    s00_tvalid = 1'b0; s01_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);

    // Single isolated samples: latency, routing, data, tlast.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (vec[i].ch == 0) begin s00_tvalid = 1'b1; s00_tdata = vec[i].data; s00_tlast = vec[i].last; end
      else begin s01_tvalid = 1'b1; s01_tdata = vec[i].data; s01_tlast = vec[i].last; end
      t_hs = -1;
      for (int k2 = 0; k2 < 20 && t_hs < 0; k2++) begin
        @(negedge clk);
        if ((vec[i].ch == 0) ? (s00_tvalid & s00_tready) : (s01_tvalid & s01_tready)) t_hs = cyc;
      end
      @(posedge clk); #1;
      s00_tvalid = 1'b0; s01_tvalid = 1'b0;
      chk("vec_handshake", (t_hs >= 0), 1);
      t_out = -1; other = 0; got = '0; got_last = 0;
      for (int k2 = 0; k2 < 60 && t_out < 0; k2++) begin
        @(negedge clk);
        if ((vec[i].ch == 0) ? m01_tvalid : m00_tvalid) other = 1;
        if ((vec[i].ch == 0) ? m00_tvalid : m01_tvalid) begin
          t_out = cyc;
          got = (vec[i].ch == 0) ? m00_tdata : m01_tdata;
          got_last = (vec[i].ch == 0) ? int'(m00_tlast) : int'(m01_tlast);
        end
      end
      chk("vec_latency", t_out - t_hs, LAT + 2);
      chk("vec_data", got, vec[i].exp_data);
      chk("vec_tlast", got_last, vec[i].exp_last);
      chk("vec_other_silent", other, 0);
      repeat (3) @(posedge clk);
    end

    // Alternation: 8 + 8 samples, grants ch0, ch1, ch0 ...
    gq.delete();
    stream(8, 8, 32'h0100_0000, 32'h0200_0000, 100, ok);
    chk("alt_stream_done", ok, 1);
    chk("alt_grant_count", gq.size(), 16);
    for (int i = 0; i < 16 && i < gq.size(); i++) chk("alt_grant_order", gq[i], i % 2);
    drain("alt_drain");

    // Backpressure on m00: ch0 stops at 32 credits, ch1 keeps flowing.
    base0 = acc0;
    c1stall = 0;
    @(posedge clk); #1;
    m00_tready = 1'b0;
    fork
      begin
        stream(40, 60, 32'h0300_0000, 32'h0400_0000, 600, ok);
      end
      begin
        for (int k2 = 0; k2 < 100; k2++) begin
          @(negedge clk);
          if (acc0 - base0 >= 32 && s01_tvalid && !s01_tready) c1stall++;
        end
        chk("bp_ch0_accepted", acc0 - base0, 32);
        chk("bp_s00_tready_low", {s00_tvalid, s00_tready}, 2'b10);
        chk("bp_ch1_no_stall", c1stall, 0);
        chk("bp_m00_tvalid", m00_tvalid, 1);
        @(posedge clk); #1;
        m00_tready = 1'b1;
      end
    join
    chk("bp_stream_done", ok, 1);
    chk("bp_ch0_total", acc0 - base0, 40);
    drain("bp_drain");

    // Reset with five samples in flight.
    stream(5, 0, 32'h0500_0000, 32'h0, 50, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete(); q1.delete();
    seen_v = 0; seen_ret = 0;
    for (int k2 = 0; k2 < 40; k2++) begin
      @(negedge clk);
      if (m00_tvalid || m01_tvalid) seen_v++;
      if (co_v) seen_ret++;
      if (err_orphan) seen_v += 100;
    end
    chk("midrst_results_returned", seen_ret, 5);
    chk("midrst_no_output_or_err", seen_v, 0);
    chk("midrst_err_orphan", err_orphan, 0);

    // Orphan result well after reset.
    do_reset();
    repeat (38) @(posedge clk);
    @(negedge clk);
    chk("orphan_before", err_orphan, 0);
    @(posedge clk); #1;
    inj_v = 1'b1;
    @(negedge clk);
    chk("orphan_same_cycle", err_orphan, 0);
    @(posedge clk); #1;
    inj_v = 1'b0;
    @(negedge clk);
    chk("orphan_set", err_orphan, 1);
    seen_v = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m00_tvalid || m01_tvalid) seen_v++;
    end
    chk("orphan_no_output", seen_v, 0);
    chk("orphan_sticky", err_orphan, 1);
    do_reset();
    @(negedge clk);
    chk("orphan_cleared_by_reset", err_orphan, 0);

`ifdef CORDIC_ARB_STATS_EN
    // Saturating per-channel accept counter.
    stream(70000, 0, 32'h0, 32'h0, 70100, ok);
    chk("stats_stream_done", ok, 1);
    @(negedge clk);
    chk("stat_ch0_cnt", stat_ch0_cnt, 16'hFFFF);
    chk("stat_ch1_cnt", stat_ch1_cnt, 16'h0000);
    chk("stat_stall_cnt", stat_stall_cnt, 16'h0000);
    drain("stats_drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
